// File: rtl/gemm_w_loader_pkg.sv
// -----------------------------------------------------------------------------
// gemm_w_loader_pkg
//   Shared definitions for the GEMM weight loader: FSM state encoding,
//   default sizes shared with the weight buffers and PE array, and the
//   length-legality helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package gemm_w_loader_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_DEF      = 512;
    localparam int COLS_DEF       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLR    = 2'd1,
        ST_LOAD   = 2'd2,
        ST_REWIND = 2'd3
    } state_e;

    // A load length is usable when it names at least one word and fits a buffer.
    function automatic logic len_legal(input int len, input int depth);
        return (len != 0) && (len <= depth);
    endfunction

endpackage

// File: rtl/gemm_w_loader_if.sv
// -----------------------------------------------------------------------------
// gemm_w_stream_if / gemm_w_buf_if
//   gemm_w_stream_if: weight stream into the loader.
//     data, valid : driven by the source (master)
//     ready       : driven by the sink (slave)
//     Handshake: a word transfers on every clock edge where valid and ready
//     are both high; the source holds data/valid stable until that edge, and
//     ready does not depend on valid.
//   gemm_w_buf_if: broadcast control bus from the loader (master) to the
//     per-column weight buffers (slave).
//     rst   : pointer reset, all columns
//     valid : per-column pointer advance
//     write : per-column write enable, only ever set together with valid
//     data  : write data, broadcast
// -----------------------------------------------------------------------------
interface gemm_w_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

interface gemm_w_buf_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 8
);
    logic                  rst;
    logic [COLS-1:0]       valid;
    logic [COLS-1:0]       write;
    logic [DATA_WIDTH-1:0] data;

    modport master (output rst, output valid, output write, output data);
    modport slave  (input rst, input valid, input write, input data);
endinterface

// File: rtl/gemm_w_loader.sv
// -----------------------------------------------------------------------------
// gemm_w_loader
//   Fills COLS weight buffers column-major from a valid/ready stream
//   (i_len words per column), rewinds their pointers, then steps all columns
//   in lockstep for playback, rewinding automatically at the end of a pass.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        begin a load (IDLE only); i_len sampled with it
//   i_len          words per column, legal 1..DEPTH
//   s              weight stream (slave side)
//   i_step         advance all buffers one entry during playback
//   wbuf           buffer control bus (master side), all registered
//   o_busy         high in CLR/LOAD/REWIND
//   o_done         1-cycle pulse, load finished and pointers rewound
//   o_loaded       buffers hold a valid set, playback enabled
//   o_wrap         1-cycle pulse, playback pass completed
//   o_err          sticky, last start had an illegal length
//   state_dbg      current FSM state
// -----------------------------------------------------------------------------
module gemm_w_loader
    import gemm_w_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int N_DEPTH    = $clog2(DEPTH),
    parameter int COLS       = COLS_DEF,
    parameter int N_COLS     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [N_DEPTH:0]   i_len,
    gemm_w_stream_if.slave     s,
    input  logic               i_step,
    gemm_w_buf_if.master       wbuf,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_loaded,
    output logic               o_wrap,
    output logic               o_err,
    output state_e             state_dbg
);

    localparam logic [N_COLS-1:0] LAST_COL = N_COLS'(COLS - 1);

    state_e                state_q, state_d;
    logic [N_DEPTH:0]      len_q, len_d;
    logic [N_COLS-1:0]     col_q, col_d;
    logic [N_DEPTH:0]      word_q, word_d;
    logic [N_DEPTH:0]      k_q, k_d;
    logic                  loaded_q, loaded_d;
    logic                  err_q, err_d;
    logic                  rst_q, rst_d;
    logic [COLS-1:0]       valid_q, valid_d;
    logic [COLS-1:0]       write_q, write_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  wrap_q, wrap_d;
    logic [N_DEPTH:0]      len_last;

    // Counters are one bit wider than the pointer so len == DEPTH compares
    // cleanly against len-1 without overflow.
    assign len_last = len_q - 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            col_q    <= '0;
            word_q   <= '0;
            k_q      <= '0;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
            rst_q    <= 1'b0;
            valid_q  <= '0;
            write_q  <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            col_q    <= col_d;
            word_q   <= word_d;
            k_q      <= k_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
            rst_q    <= rst_d;
            valid_q  <= valid_d;
            write_q  <= write_d;
            data_q   <= data_d;
            done_q   <= done_d;
            wrap_q   <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        col_d    = col_q;
        word_d   = word_q;
        k_d      = k_q;
        loaded_d = loaded_q;
        err_d    = err_q;
        rst_d    = 1'b0;
        valid_d  = '0;
        write_d  = '0;
        data_d   = data_q;
        done_d   = 1'b0;
        wrap_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A start (legal or not) takes priority and drops any step.
                if (i_start) begin
                    if (len_legal(32'(i_len), DEPTH)) begin
                        len_d    = i_len;
                        loaded_d = 1'b0;
                        err_d    = 1'b0;
                        k_d      = '0;
                        state_d  = ST_CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (i_step && loaded_q) begin
                    // Last entry of the pass rewinds instead of advancing, so
                    // pointers never reach entries beyond len.
                    if (k_q == len_last) begin
                        rst_d  = 1'b1;
                        wrap_d = 1'b1;
                        k_d    = '0;
                    end else begin
                        valid_d = '1;
                        k_d     = k_q + 1'b1;
                    end
                end
            end
            ST_CLR: begin
                rst_d   = 1'b1;
                col_d   = '0;
                word_d  = '0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (s.valid) begin
                    valid_d[col_q] = 1'b1;
                    write_d[col_q] = 1'b1;
                    data_d         = s.data;
                    if (word_q == len_last) begin
                        word_d = '0;
                        col_d  = col_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            state_d = ST_REWIND;
                        end
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end
            end
            ST_REWIND: begin
                rst_d    = 1'b1;
                done_d   = 1'b1;
                loaded_d = 1'b1;
                k_d      = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s.ready    = (state_q == ST_LOAD);
    assign wbuf.rst   = rst_q;
    assign wbuf.valid = valid_q;
    assign wbuf.write = write_q;
    assign wbuf.data  = data_q;
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_loaded   = loaded_q;
    assign o_wrap     = wrap_q;
    assign o_err      = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_gemm_w_loader.sv
// -----------------------------------------------------------------------------
// tb_gemm_w_loader
//   Directed bench for gemm_w_loader with COLS=4, DEPTH=8. A negedge monitor
//   logs every buffer-bus/pulse event into obs_q and keeps a behavioural
//   model of the four weight buffers; each scenario builds exp_q by hand and
//   compares inline.
// -----------------------------------------------------------------------------
module tb_gemm_w_loader;
    import gemm_w_loader_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int COLS  = 4;
    localparam int EW    = 3 + 2 * COLS + DW;

    logic       clk;
    logic       i_rst;
    logic       i_start;
    logic [3:0] i_len;
    logic       i_step;
    logic       o_busy, o_done, o_loaded, o_wrap, o_err;
    state_e     state_dbg;

    int checks = 0;
    int errors = 0;
    int viol   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];

    logic [DW-1:0] mem [COLS][DEPTH];
    int            ptr [COLS];

    gemm_w_stream_if #(.DATA_WIDTH(DW)) sif ();
    gemm_w_buf_if #(.DATA_WIDTH(DW), .COLS(COLS)) bif ();

    gemm_w_loader #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .COLS(COLS)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_start(i_start),
        .i_len(i_len),
        .s(sif.slave),
        .i_step(i_step),
        .wbuf(bif.master),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_loaded(o_loaded),
        .o_wrap(o_wrap),
        .o_err(o_err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor + buffer model ----------------
    function automatic logic [EW-1:0] ev(input logic r, input logic d, input logic w,
                                         input logic [COLS-1:0] v, input logic [COLS-1:0] wr,
                                         input logic [DW-1:0] dat);
        return {r, d, w, v, wr, dat};
    endfunction

    always @(negedge clk) begin
        if (bif.rst || (|bif.valid) || o_done || o_wrap)
            obs_q.push_back({bif.rst, o_done, o_wrap, bif.valid, bif.write,
                             (|bif.write) ? bif.data : {DW{1'b0}}});
        if ((|(bif.write & ~bif.valid)) || (bif.rst && (|bif.write)))
            viol++;
        for (int c = 0; c < COLS; c++) begin
            if (bif.rst === 1'b1) begin
                ptr[c] = 0;
            end else if (bif.valid[c] === 1'b1) begin
                if (bif.write[c] === 1'b1) mem[c][ptr[c]] = bif.data;
                ptr[c] = (ptr[c] + 1) % DEPTH;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_start(input int len);
        i_start = 1'b1;
        i_len   = 4'(len);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic drive_stream(input int n, input int base, input bit bp);
        bit acc;
        int t;
        for (int i = 0; i < n; i++) begin
            if (bp) begin
                sif.valid = 1'b0;
                @(posedge clk); #1;
            end
            sif.valid = 1'b1;
            sif.data  = DW'(base + i);
            acc = 1'b0;
            t   = 0;
            while (!acc && t < 20) begin
                @(negedge clk);
                if (sif.ready === 1'b1) acc = 1'b1;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL stream_timeout: word %0d not accepted within 20 cycles", i);
                sif.valid = 1'b0;
                return;
            end
        end
        sif.valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_rst = 1'b1; i_step = 1'b1; sif.valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sif.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", sif.ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", o_busy); end
        checks++; if ({o_done, o_loaded, o_wrap, o_err} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b exp 0000", {o_done, o_loaded, o_wrap, o_err}); end
        checks++; if ({bif.rst, bif.valid, bif.write, bif.data} !== '0) begin errors++; $display("FAIL rst_bus got %h exp 0", {bif.rst, bif.valid, bif.write, bif.data}); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", state_dbg, ST_IDLE); end
        i_rst = 1'b0; sif.valid = 1'b0;
        obs_q.delete();
        repeat (4) @(posedge clk);
        #1;
        i_step = 1'b0;
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rst_step_ignored got %0d events exp 0", obs_q.size()); end
        checks++; if (o_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got %b exp 0", o_loaded); end
    endtask

    task automatic test_load(input int len, input int base, input bit bp, input string name);
        logic [COLS-1:0] oh;
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, '0, '0, '0));
        for (int c = 0; c < COLS; c++) begin
            oh = COLS'(1 << c);
            for (int w = 0; w < len; w++)
                exp_q.push_back(ev(1'b0, 1'b0, 1'b0, oh, oh, DW'(base + c * len + w)));
        end
        exp_q.push_back(ev(1'b1, 1'b1, 1'b0, '0, '0, '0));
        drive_start(len);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL %s_busy got %b exp 1", name, o_busy); end
        drive_stream(COLS * len, base, bp);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_event_count got %0d exp %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_event[%0d] got %h exp %h", name, i, obs_q[i], exp_q[i]);
            end
        end
        for (int c = 0; c < COLS; c++) begin
            for (int w = 0; w < len; w++) begin
                checks++;
                if (mem[c][w] !== DW'(base + c * len + w)) begin
                    errors++;
                    $display("FAIL %s_mem[%0d][%0d] got %0d exp %0d", name, c, w, mem[c][w], base + c * len + w);
                end
            end
            checks++; if (ptr[c] !== 0) begin errors++; $display("FAIL %s_ptr[%0d] got %0d exp 0", name, c, ptr[c]); end
        end
        checks++; if ({o_loaded, o_busy, o_err, sif.ready} !== 4'b1000) begin errors++; $display("FAIL %s_final_flags got %b exp 1000", name, {o_loaded, o_busy, o_err, sif.ready}); end
    endtask

    task automatic test_playback(input int len, input int base, input int n, input string name);
        int p;
        obs_q.delete();
        exp_q.delete();
        for (int s = 1; s <= n; s++) begin
            if (s % len == 0) exp_q.push_back(ev(1'b1, 1'b0, 1'b1, '0, '0, '0));
            else              exp_q.push_back(ev(1'b0, 1'b0, 1'b0, '1, '0, '0));
        end
        for (int s = 1; s <= n; s++) begin
            i_step = 1'b1;
            @(posedge clk); #1;
            i_step = 1'b0;
            @(posedge clk); #1;
            p = s % len;
            checks++;
            if (mem[0][ptr[0]] !== DW'(base + p)) begin
                errors++;
                $display("FAIL %s_col0_step%0d got %0d exp %0d", name, s, mem[0][ptr[0]], base + p);
            end
            checks++;
            if (mem[COLS-1][ptr[COLS-1]] !== DW'(base + (COLS - 1) * len + p)) begin
                errors++;
                $display("FAIL %s_col%0d_step%0d got %0d exp %0d", name, COLS - 1, s, mem[COLS-1][ptr[COLS-1]], base + (COLS - 1) * len + p);
            end
        end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_event_count got %0d exp %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_event[%0d] got %h exp %h", name, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        obs_q.delete();
        drive_start(0);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL illegal_len0_err got %b exp 1", o_err); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL illegal_len0_busy got %b exp 0", o_busy); end
        @(posedge clk); #1;
        drive_start(9);
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL illegal_len9_err got %b exp 1", o_err); end
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL illegal_len9_state got %0d exp %0d", state_dbg, ST_IDLE); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL illegal_bus_activity got %0d events exp 0", obs_q.size()); end
    endtask

    task automatic test_reset_mid_load();
        drive_start(8);
        drive_stream(5, 300, 1'b0);
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL midrst_state got %0d exp %0d", state_dbg, ST_IDLE); end
        checks++; if ({o_loaded, o_busy, sif.ready} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b exp 000", {o_loaded, o_busy, sif.ready}); end
        @(posedge clk); #1;
    endtask

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL write_invariant got %0d violating cycles exp 0", viol);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_len = '0; i_step = 1'b0;
        sif.valid = 1'b0; sif.data = '0;
        for (int c = 0; c < COLS; c++) ptr[c] = 0;
        test_reset();
        test_load(3, 0, 1'b0, "load3");
        test_load(3, 20, 1'b1, "backpressure");
        test_playback(3, 20, 7, "play3");
        test_illegal();
        test_load(1, 50, 1'b0, "load1");
        test_playback(1, 50, 2, "play1");
        test_reset_mid_load();
        test_load(8, 200, 1'b0, "load8");
        test_playback(8, 200, 8, "play8");
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
